// File: rtl/uart_tx_fsm_pkg.sv
// Shared definitions for the UART transmitter: state encoding, oversampling
// constants and a parity helper.
package uart_tx_fsm_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = 4;
  localparam int unsigned BCNT_W     = 3;

  typedef logic [TICK_W-1:0] tick_t;
  typedef logic [BCNT_W-1:0] bcnt_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Parity bit for an 8-bit container; unused upper bits must be zero.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 16x-baud enables and flags the last enable of
// each bit; cleared synchronously when a frame is accepted.
module uart_tx_bit_timer
  import uart_tx_fsm_pkg::*;
(
  input  logic clk_i,
  input  logic rstb_i,
  input  logic baudx16_i,
  input  logic clr_i,
  output logic bit_end_o
);

  tick_t cnt_q;

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (baudx16_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_end_o = baudx16_i && (cnt_q == tick_t'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// STOP_BITS stop bits; all outputs registered.
module uart_tx_fsm
  import uart_tx_fsm_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rstb_i,
  input  logic              baudx16_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_busy_o,
  output logic              tx_done_o,
  output logic              TxD_o
);

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  bcnt_t             bitcnt_q;
  logic              par_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              txd_q;
  logic              accept;
  logic              bit_end;
  logic [7:0]        data_ext;

  assign accept   = tx_valid_i && ready_q && (state_q == S_IDLE);
  assign data_ext = 8'(tx_data_i);

  uart_tx_bit_timer u_timer (
    .clk_i     (clk_i),
    .rstb_i    (rstb_i),
    .baudx16_i (baudx16_i),
    .clr_i     (accept),
    .bit_end_o (bit_end)
  );

  // TxD_o is driven with the value of the state being entered, so the line
  // changes on the same edge as the state register.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept) begin
            shreg_q  <= tx_data_i;
            par_q    <= calc_parity(data_ext, PARITY_ODD);
            bitcnt_q <= '0;
            state_q  <= S_START;
            txd_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q  <= S_DATA;
            bitcnt_q <= '0;
            txd_q    <= shreg_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg_q <= shreg_q >> 1;
            if (bitcnt_q == bcnt_t'(DATA_W - 1)) begin
              bitcnt_q <= '0;
              if (PARITY_EN) begin
                state_q <= S_PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
              txd_q    <= shreg_q[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q  <= S_STOP;
            bitcnt_q <= '0;
            txd_q    <= 1'b1;
          end
        end
        S_STOP: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            if (bitcnt_q == bcnt_t'(STOP_BITS - 1)) begin
              state_q  <= S_IDLE;
              bitcnt_q <= '0;
              done_q   <= 1'b1;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          bitcnt_q <= '0;
          txd_q    <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready_o = ready_q;
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;
  assign TxD_o      = txd_q;

endmodule
